// File: rtl/feistel_pkg.sv
// Shared types and arithmetic for the Feistel scan-chain core.
// Latency: n/a (pure functions and types only).
// Backpressure: n/a.
// Contents: FSM state type, rotate amount, rotl helper, round function F
// and round-key schedule. Functions work on a MAX_HALF-wide word and mask
// to the live half-width, so one package serves every WIDTH instance.
package feistel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int ROT_AMT  = 3;
  localparam int MAX_HALF = 128;

  typedef logic [MAX_HALF-1:0] word_t;

  function automatic word_t half_mask(input int half);
    // For half == MAX_HALF the shift yields 0 and 0-1 wraps to all ones.
    return (word_t'(1) << half) - word_t'(1);
  endfunction

  function automatic word_t rotl(input word_t x, input int amt, input int half);
    word_t mask;
    word_t xm;
    int    a;
    mask = half_mask(half);
    xm   = x & mask;
    a    = amt % half;
    if (a == 0) begin
      return xm;
    end
    return ((xm << a) | (xm >> (half - a))) & mask;
  endfunction

  // F(R,K) = rotl(R^K, 3) ^ ((R+K) mod 2^half)
  function automatic word_t feistel_f(input word_t r, input word_t k, input int half);
    word_t mask;
    mask = half_mask(half);
    return (rotl(r ^ k, ROT_AMT, half) ^ ((r + k) & mask)) & mask;
  endfunction

  // Decrypt walks the key schedule backwards so the same round datapath
  // inverts an encryption.
  function automatic word_t round_key(input word_t key, input int idx, input int rounds,
                                      input logic enc, input int half);
    return rotl(key, enc ? idx : (rounds - 1 - idx), half);
  endfunction

endpackage

// File: rtl/feistel_round.sv
// One combinational Feistel round: l_nxt = r, r_nxt = l ^ F(r, k).
// Latency: 0 cycles (pure combinational).
// Backpressure: n/a.
// Ports: l, r, k  - current halves and round key (WIDTH/2 bits each)
//        l_nxt, r_nxt - halves after the round
module feistel_round
  import feistel_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH/2-1:0] l,
  input  logic [WIDTH/2-1:0] r,
  input  logic [WIDTH/2-1:0] k,
  output logic [WIDTH/2-1:0] l_nxt,
  output logic [WIDTH/2-1:0] r_nxt
);

  localparam int HALF = WIDTH / 2;

  assign l_nxt = r;
  assign r_nxt = l ^ HALF'(feistel_f(word_t'(r), word_t'(k), HALF));

endmodule

// File: rtl/feistel_scanchain_core.sv
// Iterative Feistel cipher, one round per cycle, with {L,R} on a scan chain.
// Latency: ROUNDS+1 cycles from the start-sampling edge to the done cycle.
// Backpressure: none; start is ignored unless idle, scan overrides everything.
// Ports: clk/rst (async active-high); start, encrypt_ndecrypt, starttext in;
//        finishtext, busy, done out; scan_enable, scan_in in, scan_out out.
// With SCAN_SECURE=1 entering scan wipes the secret state before any shift.
module feistel_scanchain_core
  import feistel_pkg::*;
#(
  parameter int                WIDTH       = 64,
  parameter int                ROUNDS      = 16,
  parameter logic [WIDTH/2-1:0] KEY        = (WIDTH/2)'(32'h5BB7A45D),
  parameter bit                SCAN_SECURE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             encrypt_ndecrypt,
  input  logic [WIDTH-1:0] starttext,
  output logic [WIDTH-1:0] finishtext,
  output logic             busy,
  output logic             done,
  input  logic             scan_enable,
  input  logic             scan_in,
  output logic             scan_out
);

  localparam int HALF = WIDTH / 2;

  state_t            state_q, state_d;
  logic [HALF-1:0]   l_q, l_d, r_q, r_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              mode_q, mode_d;
  logic [WIDTH-1:0]  ft_q, ft_d;
  logic              done_q, done_d;

  logic [HALF-1:0]   rkey;
  logic [HALF-1:0]   l_rnd, r_rnd;
  logic [WIDTH-1:0]  chain;

  assign chain = {l_q, r_q};
  assign rkey  = HALF'(round_key(word_t'(KEY), int'(cnt_q), ROUNDS, mode_q, HALF));

  feistel_round #(.WIDTH(WIDTH)) u_round (
    .l     (l_q),
    .r     (r_q),
    .k     (rkey),
    .l_nxt (l_rnd),
    .r_nxt (r_rnd)
  );

  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    ft_d    = ft_q;
    done_d  = 1'b0;

    if (scan_enable) begin
      // Any state other than FLUSH means scan just rose: wipe first, shift later.
      if (SCAN_SECURE && (state_q != FLUSH)) begin
        state_d = FLUSH;
        l_d     = '0;
        r_d     = '0;
        cnt_d   = '0;
        ft_d    = '0;
      end else begin
        {l_d, r_d} = {chain[WIDTH-2:0], scan_in};
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            l_d     = starttext[WIDTH-1:HALF];
            r_d     = starttext[HALF-1:0];
            cnt_d   = '0;
            mode_d  = encrypt_ndecrypt;
            state_d = RUN;
          end
        end
        RUN: begin
          l_d   = l_rnd;
          r_d   = r_rnd;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'(ROUNDS - 1)) begin
            // Final half-swap so decrypt can reuse the same round structure.
            ft_d    = {r_rnd, l_rnd};
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        FLUSH:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      l_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b1;
      ft_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      ft_q    <= ft_d;
      done_q  <= done_d;
    end
  end

  assign finishtext = ft_q;
  assign done       = done_q;
  assign busy       = (state_q == RUN);
  assign scan_out   = l_q[HALF-1];

endmodule

// File: tb/tb_feistel_scanchain_core.sv
// Bench for feistel_scanchain_core: three instances (defaults, 16-bit/1-round,
// non-secure scan) driven from one initial block and checked against a
// round-loop reference model.
module tb_feistel_scanchain_core;

  localparam logic [31:0] KEY = 32'h5BB7A45D;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_d, start_s, start_n, enc;
  logic [63:0] text;
  logic        scan_en_d, scan_in_d, scan_en_n, scan_in_n;

  logic [63:0] ft_d, ft_n;
  logic [15:0] ft_s;
  logic        busy_d, done_d, so_d;
  logic        busy_s, done_s, so_s;
  logic        busy_n, done_n, so_n;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  feistel_scanchain_core u_d (
    .clk(clk), .rst(rst), .start(start_d), .encrypt_ndecrypt(enc), .starttext(text),
    .finishtext(ft_d), .busy(busy_d), .done(done_d),
    .scan_enable(scan_en_d), .scan_in(scan_in_d), .scan_out(so_d));

  feistel_scanchain_core #(.WIDTH(16), .ROUNDS(1), .KEY(8'h00)) u_s (
    .clk(clk), .rst(rst), .start(start_s), .encrypt_ndecrypt(enc), .starttext(text[15:0]),
    .finishtext(ft_s), .busy(busy_s), .done(done_s),
    .scan_enable(1'b0), .scan_in(1'b0), .scan_out(so_s));

  feistel_scanchain_core #(.SCAN_SECURE(1'b0)) u_n (
    .clk(clk), .rst(rst), .start(start_n), .encrypt_ndecrypt(enc), .starttext(text),
    .finishtext(ft_n), .busy(busy_n), .done(done_n),
    .scan_enable(scan_en_n), .scan_in(scan_in_n), .scan_out(so_n));

  int          cur;
  logic        cur_busy, cur_done;
  logic [63:0] cur_ft;
  always_comb begin
    cur_busy = busy_d;
    cur_done = done_d;
    cur_ft   = ft_d;
    if (cur == 1) begin
      cur_busy = busy_s;
      cur_done = done_s;
      cur_ft   = {48'h0, ft_s};
    end else if (cur == 2) begin
      cur_busy = busy_n;
      cur_done = done_n;
      cur_ft   = ft_n;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
    int a;
    a = n % 32;
    if (a == 0) return x;
    return (x << a) | (x >> (32 - a));
  endfunction

  // Reference: 16 plain Feistel rounds on 32-bit halves, output halves swapped.
  function automatic logic [63:0] model(input logic [63:0] x, input bit e);
    logic [31:0] l, r, k, t;
    l = x[63:32];
    r = x[31:0];
    for (int i = 0; i < 16; i++) begin
      k = rotl32(KEY, e ? i : 15 - i);
      t = l ^ (rotl32(r ^ k, 3) ^ (r + k));
      l = r;
      r = t;
    end
    return {r, l};
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start_d = v;
    else if (sel == 1) start_s = v;
    else start_n = v;
  endtask

  // lat = edges after the start-sampling edge until done is seen.
  task automatic run_op(input int sel, input logic [63:0] x, input bit e,
                        input int poke, input int pause_at,
                        output logic [63:0] res, output int lat,
                        output int bcnt, output bit got);
    cur  = sel;
    enc  = e;
    text = x;
    set_start(sel, 1'b1);
    @(posedge clk); #1;
    set_start(sel, 1'b0);
    lat = 0; bcnt = 0; got = 0; res = '0;
    while (lat < 400 && !got) begin
      if (cur_busy) bcnt++;
      if (cur_done) begin
        got = 1;
        res = cur_ft;
      end else begin
        if (lat == poke) begin
          set_start(sel, 1'b1);
          text = ~x;
          enc  = ~e;
        end
        if (lat == pause_at) begin
          // Rotate the whole chain once round: state returns unchanged.
          scan_en_n = 1'b1;
          repeat (64) begin
            scan_in_n = so_n;
            @(posedge clk); #1;
          end
          scan_en_n = 1'b0;
        end
        @(posedge clk); #1;
        lat++;
        set_start(sel, 1'b0);
      end
    end
  endtask

  initial begin
    logic [63:0] res, res1, x, pat, obs, prev;
    int          lat, bcnt, ones, ndone;
    bit          got, e;

    cur = 0;
    start_d = 0; start_s = 0; start_n = 0; enc = 0; text = '0;
    scan_en_d = 0; scan_in_d = 0; scan_en_n = 0; scan_in_n = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_finishtext", ft_d, 64'h0);
    check("rst_busy", {63'h0, busy_d}, 64'h0);
    check("rst_done", {63'h0, done_d}, 64'h0);
    check("rst_scan_out", {63'h0, so_d}, 64'h0);

    // 16-bit, 1 round, zero key.
    run_op(1, 64'h0001, 1'b1, -1, -1, res, lat, bcnt, got);
    check("s_got", {63'h0, got}, 64'h1);
    check("s_latency", 64'(lat + 1), 64'd2);
    check("s_busy_cycles", 64'(bcnt), 64'd1);
    check("s_result", res, 64'h0901);

    // Default encrypt then decrypt.
    run_op(0, 64'h4, 1'b1, -1, -1, res1, lat, bcnt, got);
    check("enc_got", {63'h0, got}, 64'h1);
    check("enc_result", res1, model(64'h4, 1'b1));
    check("enc_latency", 64'(lat + 1), 64'd17);
    check("enc_busy_cycles", 64'(bcnt), 64'd16);
    run_op(0, res1, 1'b0, -1, -1, res, lat, bcnt, got);
    check("dec_result", res, 64'h4);
    check("dec_busy_cycles", 64'(bcnt), 64'd16);

    // Random blocks: result vs model, and inverse on the other instance.
    for (int it = 0; it < 6; it++) begin
      x = {$urandom, $urandom};
      e = 1'($urandom_range(0, 1));
      run_op(0, x, e, -1, -1, res, lat, bcnt, got);
      check("rand_result", res, model(x, e));
      run_op(2, res, ~e, -1, -1, res1, lat, bcnt, got);
      check("rand_inverse", res1, x);
    end

    // start while busy is ignored.
    x = {$urandom, $urandom};
    run_op(0, x, 1'b1, 3, -1, res, lat, bcnt, got);
    check("busy_start_result", res, model(x, 1'b1));
    check("busy_start_latency", 64'(lat + 1), 64'd17);

    // Non-secure scan pause mid-run, chain rotated back to itself.
    x = {$urandom, $urandom};
    run_op(2, x, 1'b0, -1, 5, res, lat, bcnt, got);
    check("pause_got", {63'h0, got}, 64'h1);
    check("pause_result", res, model(x, 1'b0));
    check("pause_busy_cycles", 64'(bcnt), 64'd16);

    // start together with scan: scan wins, no run.
    prev = ft_n;
    text = {$urandom, $urandom};
    start_n = 1; scan_en_n = 1; scan_in_n = 1'($urandom);
    @(posedge clk); #1;
    start_n = 0; scan_en_n = 0;
    check("start_scan_busy", {63'h0, busy_n}, 64'h0);
    @(posedge clk); #1;
    check("start_scan_busy2", {63'h0, busy_n}, 64'h0);
    check("start_scan_done", {63'h0, done_n}, 64'h0);
    check("start_scan_ft", ft_n, prev);

    // Non-secure scan load and unload.
    pat = 64'hFEF9545BB7A45DFD;
    scan_en_n = 1;
    for (int i = 0; i < 64; i++) begin
      scan_in_n = pat[63 - i];
      @(posedge clk); #1;
    end
    obs = '0;
    for (int i = 0; i < 64; i++) begin
      obs[63 - i] = so_n;
      scan_in_n = 1'b0;
      @(posedge clk); #1;
    end
    scan_en_n = 0;
    check("scan_roundtrip", obs, pat);

    // Secure scan entry mid-run.
    x = {$urandom, $urandom};
    enc = 1; text = x; start_d = 1;
    @(posedge clk); #1;
    start_d = 0;
    repeat (8) @(posedge clk);
    #1;
    check("pre_flush_busy", {63'h0, busy_d}, 64'h1);
    scan_en_d = 1; scan_in_d = 0; ndone = 0; ones = 0;
    @(posedge clk); #1;
    ndone += int'(done_d);
    check("flush_busy", {63'h0, busy_d}, 64'h0);
    for (int i = 0; i < 64; i++) begin
      ones += int'(so_d);
      @(posedge clk); #1;
      ndone += int'(done_d);
    end
    scan_en_d = 0;
    check("flush_scan_ones", 64'(ones), 64'd0);
    check("flush_done_count", 64'(ndone), 64'd0);
    check("flush_finishtext", ft_d, 64'h0);
    @(posedge clk); #1;
    check("flush_exit_busy", {63'h0, busy_d}, 64'h0);
    check("flush_exit_done", {63'h0, done_d}, 64'h0);

    // Reset mid-run, then a clean run.
    enc = 1; text = 64'h4; start_d = 1;
    @(posedge clk); #1;
    start_d = 0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #2;
    check("mid_rst_busy", {63'h0, busy_d}, 64'h0);
    check("mid_rst_done", {63'h0, done_d}, 64'h0);
    check("mid_rst_scan_out", {63'h0, so_d}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_done", {63'h0, done_d}, 64'h0);
    run_op(0, 64'h4, 1'b1, -1, -1, res, lat, bcnt, got);
    check("post_rst_result", res, model(64'h4, 1'b1));
    check("post_rst_latency", 64'(lat + 1), 64'd17);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
